// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache with line refill over a burst read channel.
// Serves one fetch at a time and counts completed hits and refills.
module icache_dm #(
  parameter int LINE_WORDS = 8,
  parameter int SETS       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] from_cpu_inst_req_addr,
  input  logic        from_cpu_inst_req_valid,
  output logic        to_cpu_inst_req_ready,
  output logic [31:0] to_cpu_cache_rsp_data,
  output logic        to_cpu_cache_rsp_valid,
  input  logic        from_cpu_cache_rsp_ready,
  output logic [31:0] to_mem_rd_req_addr,
  output logic        to_mem_rd_req_valid,
  input  logic        from_mem_rd_req_ready,
  input  logic [31:0] from_mem_rd_rsp_data,
  input  logic        from_mem_rd_rsp_valid,
  input  logic        from_mem_rd_rsp_last,
  output logic        to_mem_rd_rsp_ready,
  output logic [31:0] cache_hit_cnt,
  output logic [31:0] cache_miss_cnt,
  output logic [2:0]  fsm_state
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - OFF_W - IDX_W - 2;
  localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // a valid source holds its payload stable until that edge.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    MEM_REQ = 3'd2,
    RECV    = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      addr_r;
  logic [OFF_W-1:0] beat_q;
  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS][LINE_WORDS];
  logic [31:0]      hit_cnt_q;
  logic [31:0]      miss_cnt_q;

  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic [TAG_W-1:0] tag;
  logic             hit;

  assign idx = addr_r[OFF_W+2 +: IDX_W];
  assign off = addr_r[2 +: OFF_W];
  assign tag = addr_r[31 -: TAG_W];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);

  logic req_acc, mem_req_acc, beat_acc, rsp_acc;

  always_comb begin
    state_d                 = state_q;
    to_cpu_inst_req_ready   = 1'b0;
    to_cpu_cache_rsp_valid  = 1'b0;
    to_mem_rd_req_valid     = 1'b0;
    to_mem_rd_rsp_ready     = 1'b0;
    unique case (state_q)
      IDLE: begin
        to_cpu_inst_req_ready = 1'b1;
        if (from_cpu_inst_req_valid) state_d = LOOKUP;
      end
      LOOKUP: state_d = hit ? RESP : MEM_REQ;
      MEM_REQ: begin
        to_mem_rd_req_valid = 1'b1;
        if (from_mem_rd_req_ready) state_d = RECV;
      end
      RECV: begin
        to_mem_rd_rsp_ready = 1'b1;
        if (from_mem_rd_rsp_valid && from_mem_rd_rsp_last) state_d = RESP;
      end
      RESP: begin
        to_cpu_cache_rsp_valid = 1'b1;
        if (from_cpu_cache_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      to_cpu_inst_req_ready  = 1'b0;
      to_cpu_cache_rsp_valid = 1'b0;
      to_mem_rd_req_valid    = 1'b0;
      to_mem_rd_rsp_ready    = 1'b0;
      state_d                = IDLE;
    end
  end

  assign req_acc     = to_cpu_inst_req_ready && from_cpu_inst_req_valid;
  assign mem_req_acc = to_mem_rd_req_valid && from_mem_rd_req_ready;
  assign beat_acc    = to_mem_rd_rsp_ready && from_mem_rd_rsp_valid;
  assign rsp_acc     = to_cpu_cache_rsp_valid && from_cpu_cache_rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_r     <= '0;
      beat_q     <= '0;
      valid_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (req_acc) addr_r <= from_cpu_inst_req_addr;
      if (state_q == LOOKUP && hit) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (mem_req_acc) beat_q <= '0;
      else if (beat_acc) beat_q <= beat_q + OFF_W'(1);
      if (beat_acc && from_mem_rd_rsp_last) begin
        valid_q[idx] <= 1'b1;
        miss_cnt_q   <= miss_cnt_q + 32'd1;
      end
    end
  end

  // Line storage is not reset; only the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (!rst && beat_acc) begin
      data_q[idx][beat_q] <= from_mem_rd_rsp_data;
      if (from_mem_rd_rsp_last) tag_q[idx] <= tag;
    end
  end

  assign to_mem_rd_req_addr    = rst ? 32'd0 : (addr_r & LINE_MASK);
  assign to_cpu_cache_rsp_data = (state_q == RESP && !rst) ? data_q[idx][off] : 32'd0;
  assign cache_hit_cnt         = hit_cnt_q;
  assign cache_miss_cnt        = miss_cnt_q;
  assign fsm_state             = state_q;

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold miss, hit, conflict, backpressure and mid-refill reset.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_addr;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] rsp_data;
  logic        rsp_valid;
  logic        cpu_rsp_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_valid;
  logic        mem_rsp_last;
  logic        mem_rsp_ready;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  logic [2:0]  fsm_state;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  icache_dm dut (
    .clk                      (clk),
    .rst                      (rst),
    .from_cpu_inst_req_addr   (req_addr),
    .from_cpu_inst_req_valid  (req_valid),
    .to_cpu_inst_req_ready    (req_ready),
    .to_cpu_cache_rsp_data    (rsp_data),
    .to_cpu_cache_rsp_valid   (rsp_valid),
    .from_cpu_cache_rsp_ready (cpu_rsp_ready),
    .to_mem_rd_req_addr       (mem_req_addr),
    .to_mem_rd_req_valid      (mem_req_valid),
    .from_mem_rd_req_ready    (mem_req_ready),
    .from_mem_rd_rsp_data     (mem_rsp_data),
    .from_mem_rd_rsp_valid    (mem_rsp_valid),
    .from_mem_rd_rsp_last     (mem_rsp_last),
    .to_mem_rd_rsp_ready      (mem_rsp_ready),
    .cache_hit_cnt            (hit_cnt),
    .cache_miss_cnt           (miss_cnt),
    .fsm_state                (fsm_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  // Present one fetch, leaving the bench one cycle past LOOKUP.
  task automatic issue(input logic [31:0] a);
    chk("idle_req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = a;
    step();
    req_valid = 1'b0;
    req_addr  = $urandom;
    chk("lookup_req_ready", req_ready, 0);
    chk("lookup_rsp_valid", rsp_valid, 0);
    chk("lookup_mem_valid", mem_req_valid, 0);
    step();
  endtask

  task automatic refill(input logic [31:0] exp_addr, input logic [31:0] base,
                        input int stall, input int gap);
    chk("mem_req_valid", mem_req_valid, 1);
    chk("mem_req_addr", mem_req_addr, exp_addr);
    for (int i = 0; i < stall; i++) begin
      mem_req_ready = 1'b0;
      step();
      chk("mem_stall_valid", mem_req_valid, 1);
      chk("mem_stall_addr", mem_req_addr, exp_addr);
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1) begin
        for (int g = 0; g < gap; g++) begin
          mem_rsp_valid = 1'b0;
          mem_rsp_data  = $urandom;
          mem_rsp_last  = 1'b1;
          step();
        end
      end
      chk("recv_rsp_ready", mem_rsp_ready, 1);
      chk("recv_rsp_valid", rsp_valid, 0);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = base + 32'(i);
      mem_rsp_last  = (i == 7);
      step();
    end
    mem_rsp_valid = 1'b0;
    mem_rsp_last  = 1'b0;
  endtask

  task automatic respond(input logic [31:0] exp, input int hold);
    for (int i = 0; i < hold; i++) begin
      chk("rsp_hold_valid", rsp_valid, 1);
      chk("rsp_hold_data", rsp_data, exp);
      step();
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data", rsp_data, exp);
    cpu_rsp_ready = 1'b1;
    step();
    cpu_rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_rsp_idle", req_ready, 1);
  endtask

  initial begin
    rst           = 1'b1;
    req_addr      = '0;
    req_valid     = 1'b0;
    cpu_rsp_ready = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_valid = 1'b0;
    mem_rsp_last  = 1'b0;
    step();
    step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_mem_rsp_ready", mem_rsp_ready, 0);
    chk("rst_mem_addr", mem_req_addr, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_state", fsm_state, 0);
    rst = 1'b0;
    step();

    // Cold miss with memory request stalled 5 cycles and response held 3 cycles.
    issue(32'h0000_0010);
    refill(32'h0000_0000, 32'h1000, 5, 0);
    chk("cold_miss_cnt", miss_cnt, 1);
    respond(32'h1004, 3);

    // Hit in the same line.
    issue(32'h0000_001C);
    chk("hit_no_mem", mem_req_valid, 0);
    chk("hit_cnt_1", hit_cnt, 1);
    respond(32'h1007, 0);

    // Conflict on index 0 with idle cycles inside the burst.
    issue(32'h0000_0100);
    refill(32'h0000_0100, 32'h2000, 0, 2);
    respond(32'h2000, 0);
    chk("conflict_miss_cnt", miss_cnt, 2);

    // Original line was evicted.
    issue(32'h0000_0010);
    refill(32'h0000_0000, 32'h3000, 0, 1);
    respond(32'h3004, 0);
    issue(32'h0000_0014);
    chk("rehit_no_mem", mem_req_valid, 0);
    respond(32'h3005, 0);

    // Second set is independent of set 0.
    issue(32'h0000_0020);
    refill(32'h0000_0020, 32'h4000, 0, 0);
    respond(32'h4000, 0);
    issue(32'h0000_003C);
    chk("set1_hit_no_mem", mem_req_valid, 0);
    respond(32'h4007, 2);
    chk("hit_cnt_3", hit_cnt, 3);
    chk("miss_cnt_4", miss_cnt, 4);

    // Only the top tag bit differs from the resident line: must miss; reset mid-refill.
    issue(32'h8000_0010);
    chk("fulltag_mem_valid", mem_req_valid, 1);
    chk("fulltag_mem_addr", mem_req_addr, 32'h8000_0000);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h9000 + 32'(i);
      step();
    end
    chk("mid_recv_ready", mem_rsp_ready, 1);
    rst = 1'b1;
    step();
    chk("abort_mem_rsp_ready", mem_rsp_ready, 0);
    chk("abort_req_ready", req_ready, 0);
    chk("abort_mem_valid", mem_req_valid, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_state", fsm_state, 0);
    chk("abort_hit_cnt", hit_cnt, 0);
    chk("abort_miss_cnt", miss_cnt, 0);
    rst = 1'b0;
    mem_rsp_data = 32'h9003;
    chk("late_beat_ready", mem_rsp_ready, 0);
    step();
    chk("late_beat_state", fsm_state, 0);
    mem_rsp_valid = 1'b0;

    // Valid bits were cleared: refetch misses again.
    issue(32'h0000_0010);
    refill(32'h0000_0000, 32'h5000, 0, 0);
    respond(32'h5004, 0);
    chk("post_rst_miss_cnt", miss_cnt, 1);
    chk("post_rst_hit_cnt", hit_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
